// File: rtl/regbank32_writer_if.sv
// Write-side bundle of the 32-entry register bank: write handshake, clear request,
// sweep status, write strobe and the flattened entry bus.
interface regbank32_writer_if #(
  parameter int N = 32
);
  logic            wr_valid;
  logic            wr_ready;
  logic [4:0]      wr_addr;
  logic [N-1:0]    wr_data;
  logic            clear_req;
  logic            busy;
  logic [31:0]     wr_onehot;
  logic [32*N-1:0] regs_flat;

  modport master (
    output wr_valid, wr_addr, wr_data, clear_req,
    input  wr_ready, busy, wr_onehot, regs_flat
  );

  modport slave (
    input  wr_valid, wr_addr, wr_data, clear_req,
    output wr_ready, busy, wr_onehot, regs_flat
  );
endinterface

// File: rtl/regbank32_writer.sv
// 32 x N register bank write side with a one-entry-per-cycle bulk clear; writes land
// one cycle after accept. wr_ready drops for the 32-cycle sweep and nothing is buffered.
module regbank32_writer #(
  parameter int         N           = 32,
  parameter logic [N-1:0] CLEAR_VALUE = '0,
  parameter bit         ZERO_REG    = 1'b0
) (
  input logic               clk,
  input logic               rst,
  regbank32_writer_if.slave bus
);
  typedef enum logic {IDLE, CLEAR} state_t;

  state_t       state_q, state_d;
  logic [4:0]   idx_q, idx_d;
  logic         ready_q, ready_d;
  logic         busy_q, busy_d;
  logic [31:0]  onehot_q, onehot_d;
  logic [N-1:0] regs_q [32];
  logic [N-1:0] regs_d [32];
  logic         accept;

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    ready_d  = ready_q;
    busy_d   = busy_q;
    onehot_d = '0;
    regs_d   = regs_q;
    accept   = bus.wr_valid && ready_q;

    // A write and a clear start may share an edge; the sweep later overwrites the entry.
    if (accept) begin
      onehot_d = 32'd1 << bus.wr_addr;
      if (!(ZERO_REG && bus.wr_addr == 5'd0)) begin
        regs_d[bus.wr_addr] = bus.wr_data;
      end
    end

    case (state_q)
      IDLE: begin
        if (bus.clear_req) begin
          state_d = CLEAR;
          idx_d   = 5'd0;
          ready_d = 1'b0;
          busy_d  = 1'b1;
        end
      end
      CLEAR: begin
        regs_d[idx_q] = CLEAR_VALUE;
        idx_d         = idx_q + 5'd1;
        if (idx_q == 5'd31) begin
          state_d = IDLE;
          ready_d = 1'b1;
          busy_d  = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      idx_q    <= 5'd0;
      ready_q  <= 1'b1;
      busy_q   <= 1'b0;
      onehot_q <= '0;
      for (int k = 0; k < 32; k++) begin
        regs_q[k] <= CLEAR_VALUE;
      end
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      ready_q  <= ready_d;
      busy_q   <= busy_d;
      onehot_q <= onehot_d;
      regs_q   <= regs_d;
    end
  end

  assign bus.wr_ready  = ready_q;
  assign bus.busy      = busy_q;
  assign bus.wr_onehot = onehot_q;

  for (genvar k = 0; k < 32; k++) begin : g_flat
    if (ZERO_REG && k == 0) begin : g_zero
      assign bus.regs_flat[k*N +: N] = CLEAR_VALUE;
    end else begin : g_reg
      assign bus.regs_flat[k*N +: N] = regs_q[k];
    end
  end
endmodule

// File: tb/tb_regbank32_writer.sv
// Drives two banks (ZERO_REG off/on) with identical stimulus and scoreboards both
// against a countdown-based model of the write/clear rules.
module tb_regbank32_writer;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  regbank32_writer_if #(.N(32)) bus0 ();
  regbank32_writer_if #(.N(32)) bus1 ();

  assign bus1.wr_valid  = bus0.wr_valid;
  assign bus1.wr_addr   = bus0.wr_addr;
  assign bus1.wr_data   = bus0.wr_data;
  assign bus1.clear_req = bus0.clear_req;

  regbank32_writer #(.N(32), .CLEAR_VALUE(32'h0), .ZERO_REG(1'b0)) dut0 (
    .clk(clk), .rst(rst), .bus(bus0)
  );
  regbank32_writer #(.N(32), .CLEAR_VALUE(32'h0), .ZERO_REG(1'b1)) dut1 (
    .clk(clk), .rst(rst), .bus(bus1)
  );

  typedef struct {
    bit          chk_ready;
    bit          ready;
    bit          busy;
    logic [31:0] onehot;
    logic [1023:0] flat0;
    logic [1023:0] flat1;
  } exp_t;

  exp_t q[$];
  int n_cmp = 0;
  int n_bad = 0;

  // Reference: m_left counts sweep cycles still owed; 0 means idle.
  logic [31:0] m_regs [32];
  int          m_left;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_cmp++;
    if (act !== expv) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, expv, $time);
    end
  endtask

  task automatic chk_flat(input string name, input logic [1023:0] act, input logic [1023:0] expv);
    n_cmp++;
    if (act !== expv) begin
      n_bad++;
      for (int k = 0; k < 32; k++) begin
        if (act[k*32 +: 32] !== expv[k*32 +: 32]) begin
          $display("FAIL %s entry %0d: got %h expected %h at %0t",
                   name, k, act[k*32 +: 32], expv[k*32 +: 32], $time);
          break;
        end
      end
    end
  endtask

  task automatic push_exp(input bit chk_ready, input logic [31:0] oh);
    exp_t e;
    e.chk_ready = chk_ready;
    e.ready     = (m_left == 0);
    e.busy      = (m_left > 0);
    e.onehot    = oh;
    for (int k = 0; k < 32; k++) begin
      e.flat0[k*32 +: 32] = m_regs[k];
      e.flat1[k*32 +: 32] = (k == 0) ? 32'h0 : m_regs[k];
    end
    q.push_back(e);
  endtask

  // Called at a negedge; applies inputs, advances the model one edge, waits next negedge.
  task automatic step_in(input bit v, input logic [4:0] a, input logic [31:0] d,
                         input bit c, output bit acc);
    logic [31:0] oh;
    bus0.wr_valid  = v;
    bus0.wr_addr   = a;
    bus0.wr_data   = d;
    bus0.clear_req = c;
    acc = v && (m_left == 0);
    oh  = acc ? (32'd1 << a) : 32'd0;
    if (acc) m_regs[a] = d;
    if (m_left > 0) begin
      m_regs[32 - m_left] = 32'h0;
      m_left--;
    end else if (c) begin
      m_left = 32;
    end
    push_exp(1'b1, oh);
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    bit acc;
    for (int i = 0; i < n; i++) step_in(1'b0, 5'd0, 32'h0, 1'b0, acc);
  endtask

  task automatic do_reset();
    rst            = 1'b1;
    bus0.wr_valid  = 1'b0;
    bus0.wr_addr   = 5'd0;
    bus0.wr_data   = 32'h0;
    bus0.clear_req = 1'b0;
    q.delete();
    for (int k = 0; k < 32; k++) m_regs[k] = 32'h0;
    m_left = 0;
    push_exp(1'b0, 32'h0);
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Holds a write until the model accepts it; clr_at pulses clear_req on that attempt.
  task automatic write_hold(input logic [4:0] a, input logic [31:0] d, input int clr_at);
    bit acc = 1'b0;
    for (int i = 0; i < 100 && !acc; i++) step_in(1'b1, a, d, (i == clr_at), acc);
    n_cmp++;
    if (!acc) begin
      n_bad++;
      $display("FAIL write_hold addr %0d: not accepted within 100 cycles", a);
    end
  endtask

  always begin
    exp_t e;
    @(posedge clk);
    #1;
    if (q.size() > 0) begin
      e = q.pop_front();
      if (e.chk_ready) begin
        chk("ready0", {31'h0, bus0.wr_ready}, {31'h0, e.ready});
        chk("ready1", {31'h0, bus1.wr_ready}, {31'h0, e.ready});
      end
      chk("busy0", {31'h0, bus0.busy}, {31'h0, e.busy});
      chk("busy1", {31'h0, bus1.busy}, {31'h0, e.busy});
      chk("onehot0", bus0.wr_onehot, e.onehot);
      chk("onehot1", bus1.wr_onehot, e.onehot);
      chk_flat("regs0", bus0.regs_flat, e.flat0);
      chk_flat("regs1", bus1.regs_flat, e.flat1);
    end
  end

  initial begin
    bit          acc;
    bit          pend;
    bit          v;
    logic [4:0]  a;
    logic [31:0] d;
    bus0.wr_valid  = 1'b0;
    bus0.wr_addr   = 5'd0;
    bus0.wr_data   = 32'h0;
    bus0.clear_req = 1'b0;
    @(negedge clk);
    do_reset();

    step_in(1'b1, 5'd5, 32'hDEADBEEF, 1'b0, acc);
    step_in(1'b1, 5'd31, 32'h1, 1'b0, acc);
    idle(2);
    do_reset();

    for (int k = 0; k < 32; k++) step_in(1'b1, 5'(k), 32'(k + 100), 1'b0, acc);
    step_in(1'b0, 5'd0, 32'h0, 1'b1, acc);
    write_hold(5'd9, 32'hA5A5_0009, 10);
    idle(3);

    step_in(1'b1, 5'd7, 32'h55, 1'b1, acc);
    idle(35);

    step_in(1'b1, 5'd0, 32'hFF, 1'b0, acc);
    step_in(1'b1, 5'd3, 32'h33, 1'b1, acc);
    for (int i = 0; i < 40 && m_left != 20; i++) idle(1);
    do_reset();
    idle(2);

    pend = 1'b0;
    v = 1'b0; a = 5'd0; d = 32'h0;
    for (int i = 0; i < 3000; i++) begin
      if (!pend) begin
        v = ($urandom_range(0, 2) != 0);
        a = 5'($urandom);
        d = $urandom;
      end
      step_in(v, a, d, ($urandom_range(0, 59) == 0), acc);
      pend = v && !acc;
    end
    idle(40);

    @(posedge clk);
    #2;
    n_cmp++;
    if (q.size() != 0) begin
      n_bad++;
      $display("FAIL drain: got %0d expectations left, expected 0", q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
